// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI-to-Wishbone bridge.
// No logic of its own; imported by the bridge and its watchdog.
// No flow control here; see the importing modules.
package obi_wb_pkg;

    // Bridge FSM: waiting for a request, Wishbone cycle open, response pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter width able to hold the value cycles itself.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Watchdog for a hung Wishbone cycle; compiled only with OBI_WB_TIMEOUT_EN.
// Latency: expired_o is combinational in the TIMEOUT_CYCLES-th busy cycle.
// No backpressure; it only observes start/busy from the bridge.
`ifdef OBI_WB_TIMEOUT_EN
module bus_watchdog
    import obi_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expired_o
);

    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    // The count holds completed waiting cycles, so the cycle that would
    // complete the limit is the one that fires.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear when a new Wishbone cycle opens, count every cycle still waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = busy && (cnt_q == LAST);

endmodule
`endif

// File: rtl/obi_wb_bridge.sv
// OBI req/gnt/rvalid port to Wishbone classic master, one transfer in flight.
// Latency: grant -> cyc next cycle; ack in cycle k -> rvalid in cycle k+1.
// Backpressure: gnt_o only in IDLE/RESP; BUS waits on ack/err (or watchdog with OBI_WB_TIMEOUT_EN).
module obi_wb_bridge
    import obi_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    state_t                    state_q, state_d;
    logic                      cyc_d;
    logic                      we_d;
    logic [ADDR_WIDTH-1:0]     addr_d;
    logic [DATA_WIDTH/8-1:0]   sel_d;
    logic [DATA_WIDTH-1:0]     wdata_d;
    logic                      rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_d;
    logic                      err_d;
    logic                      timeout;
    logic                      term_err;

`ifdef OBI_WB_TIMEOUT_EN
    logic wd_busy;

    // The watchdog only counts cycles in which the slave has not answered.
    assign wd_busy = (state_q == BUS) && !wb_ack_i && !wb_err_i;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk       (clk),
        .rst       (rst),
        .start     (gnt_o),
        .busy      (wd_busy),
        .expired_o (timeout)
    );
`else
    // Without the watchdog the limit has no meaning; keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // A request is accepted only when no Wishbone cycle is open.
    assign gnt_o    = req_i && (state_q == IDLE || state_q == RESP);
    assign term_err = wb_err_i || timeout;
    assign wb_stb_o = wb_cyc_o;

    // Next state, next Wishbone outputs and next response registers.
    always_comb begin
        state_d  = state_q;
        cyc_d    = wb_cyc_o;
        we_d     = wb_we_o;
        addr_d   = wb_addr_o;
        sel_d    = wb_sel_o;
        wdata_d  = wb_data_o;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (gnt_o) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    sel_d   = be_i;
                    wdata_d = wdata_i;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // Error (slave or watchdog) wins over a simultaneous ack.
                if (wb_ack_i || term_err) begin
                    state_d  = RESP;
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = term_err;
                    rdata_d  = (!wb_we_o && !term_err) ? wb_data_i : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // Register every Wishbone-side output and the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_sel_o  <= '0;
            wb_data_o <= '0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_cyc_o  <= cyc_d;
            wb_we_o   <= we_d;
            wb_addr_o <= addr_d;
            wb_sel_o  <= sel_d;
            wb_data_o <= wdata_d;
            rvalid_o  <= rvalid_d;
            rdata_o   <= rdata_d;
            err_o     <= err_d;
        end
    end

endmodule

// File: doc/obi_wb_bridge.md
# obi_wb_bridge

Converts the core's OBI-style request/grant/rvalid memory port into a Wishbone classic single-cycle-per-transfer master. One instance goes on the instruction port and one on the data port, between the processor core and the Controller's Wishbone slave ports. It replaces ad-hoc ack/data re-registering in the top wrappers. It holds one transfer in flight and registers every Wishbone-side output. An optional watchdog terminates hung transfers with an error.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; byte-enable/sel width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles of cyc high; used only with OBI_WB_TIMEOUT_EN
- clk  in  1  single clock for both sides
- rst  in  1  reset, asynchronous, active-high
- req_i  in  1  core request
- gnt_o  out  1  request accepted this cycle (combinational)
- addr_i  in  ADDR_WIDTH  request address
- we_i  in  1  1 = write
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one-cycle pulse per granted request
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
- err_o  out  1  response error, valid with rvalid_o
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe, always equal
- wb_we_o  out  1  Wishbone write enable
- wb_addr_o  out  ADDR_WIDTH  Wishbone address, passed unmodified
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select
- wb_data_o  out  DATA_WIDTH  Wishbone write data
- wb_data_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error (tie 0 if absent)

## Operation
- States: IDLE, BUS, RESP.
- gnt_o = req_i && (state == IDLE || state == RESP).
- On req_i && gnt_o: latch addr/we/be/wdata into the WB output registers, set cyc/stb, go to BUS.
- BUS: hold cyc/stb and all WB outputs stable until wb_ack_i or wb_err_i is sampled high.
  - On either: drop cyc/stb next cycle and go to RESP.
  - Latch rdata = (read && !err) ? wb_data_i : 0, and err = wb_err_i.
  - ack and err together: err wins.
- RESP: rvalid_o = 1 for exactly this cycle with the latched rdata/err.
  - If a new request is granted in RESP, go directly to BUS and reassert cyc/stb.
  - Otherwise return to IDLE.
- rvalid_o pulses for reads and writes alike. At most one outstanding transfer.
- wb_ack_i/wb_err_i sampled while not in BUS are ignored.
- rdata_o/err_o are don't-care outside rvalid_o but are driven to 0 in IDLE.

## Timing
- Reset values: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_addr_o/wb_sel_o/wb_data_o=0, rvalid_o=0, rdata_o=0, err_o=0. gnt_o follows req_i, since state is IDLE.
- Grant in cycle 0 -> cyc/stb high in cycle 1. Ack sampled in cycle k≥1 -> rvalid_o in cycle k+1, cyc low in cycle k+1.
- Minimum request-to-rvalid latency is 2 cycles (ack in cycle 1).
- Back-to-back throughput is one transfer per 2 cycles: the grant in the RESP cycle overlaps the rvalid of the previous transfer.
- Reset asserted mid-transfer immediately clears cyc/stb and any pending response. No rvalid is issued for the aborted transfer.

## Configuration
- OBI_WB_TIMEOUT_EN defined:
  - A counter clears on entering BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES, the bridge treats that cycle as wb_err_i: drop cyc, RESP with err_o=1, rdata_o=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter. BUS waits indefinitely for ack/err.

## Structure
- Package obi_wb_pkg: state enum type (IDLE, BUS, RESP) and a function returning the timeout counter width.
- Sub-module bus_watchdog (clk, rst, start, busy, expired_o), instantiated only under OBI_WB_TIMEOUT_EN.

## Test plan
- Read with ack in cycle 1: req addr 0x0000_0010, wb_data_i 0xDEAD_BEEF -> gnt cycle 0, cyc cycles 1 only, rvalid cycle 2 with rdata 0xDEAD_BEEF, err 0.
- Write with 3-cycle ack delay: addr 0x100, wdata 0x1234_5678, be 0b0011 -> sel 0b0011, we=1, data stable cycles 1–3, rvalid cycle 4 with rdata 0.
- Back-to-back reads, req held high, ack immediate -> gnt in cycles 0, 2, 4; rvalid in 2, 4, 6; cyc low in 2 and 4 for one cycle each.
- wb_ack_i and wb_err_i high together -> rvalid with err_o=1, rdata_o=0.
- Reset asserted in BUS -> cyc/stb low in the same cycle, no rvalid after release, next request proceeds normally.
- With OBI_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> cyc falls after 8 BUS cycles, rvalid with err_o=1 in the following cycle.
